vec_scan_ctrl: RTL and testbench
================================

# vec_scan_ctrl

Sequencing controller that walks a captured ROWS×COLS-bit filter vector in nested row/column order. For each element it emits the element index and a transformed data word over a valid/ready stream, one element per accepted handshake. It sits between the generate-built filter vector and any per-element consumer (display or checker stage), replacing open-coded nested loops with a single restartable scan engine.

## Interface
- ROWS, default 4: outer loop count, ≥1.
- COLS, default 8: inner loop count, ≥1.
- DW, default 8: output data width, ≥2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a scan; sampled only in IDLE.
- mode  input  2  transform select: 0 plain, 1 invert, 2 invert+offset, 3 reserved (treated as 0).
- offset  input  DW  addend for mode 2.
- vec  input  ROWS*COLS  element i = vec[i].
- busy  output  1  high whenever state ≠ IDLE.
- out_valid  output  1  element available.
- out_ready  input  1  consumer accepts element.
- out_index  output  $clog2(ROWS*COLS) (min 1)  element index = row*COLS + col.
- out_data  output  DW  transformed element.
- out_last  output  1  high with the final element.
- done  output  1  one-cycle pulse after final handshake.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start=1 captures vec, mode and offset into registers, clears row/col to 0, moves to SCAN. Later changes on the inputs do not affect the scan in progress.
- SCAN:
  - out_valid=1.
  - out_index = row*COLS+col.
  - out_last = (row==ROWS-1 && col==COLS-1).
- Handshake = out_valid && out_ready.
  - On a non-last handshake: col increments. At COLS-1, col wraps to 0 and row increments.
  - On the last handshake: go to DONE, drop out_valid.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in SCAN and DONE. No queuing.
- Data transform, with b = captured bit zero-extended to DW:
  - mode 0: b.
  - mode 1: ~b (bit 0 gives all ones; bit 1 gives all ones with LSB 0).
  - mode 2: (~b + offset) mod 2^DW, carry discarded.
- Backpressure: with out_ready=0, out_valid, out_index, out_data and out_last hold stable.
- Reset, any time including mid-scan:
  - state → IDLE; busy, out_valid, out_last, done, out_index, out_data, row, col all → 0.
  - An aborted scan produces no done pulse.

## Timing
- All outputs are registered.
- start high at edge t → busy and out_valid high after edge t, with out_index=0.
- With out_ready held high: one element per cycle. The final handshake occurs at edge t+ROWS*COLS, done is high for the following cycle, and busy drops one cycle later.
- Minimum start-to-start spacing: ROWS*COLS+2 cycles.
- ROWS=COLS=1: a single element with out_last=1 on it.

## Structure
- Package vec_scan_pkg: mode enum (MODE_PLAIN, MODE_INV, MODE_INV_OFS), state enum (S_IDLE, S_SCAN, S_DONE).
- Sub-module scan_counter:
  - Nested row/col counter with clear and advance inputs.
  - Outputs row, col, flat index and last flag.
  - Parameterized by ROWS and COLS.
- Top module holds the FSM, capture registers and data transform.

## Test plan
- Defaults, vec bit n = n&1, mode 0, out_ready=1 → indices 0..31 on consecutive cycles, data alternating 0,1, out_last only at index 31, done exactly once.
- Same vec, mode 2, offset=5 → even indices data 0x04, odd indices data 0x03; mode 1 → 0xFF/0xFE.
- out_ready toggled pseudo-randomly → every element appears exactly once, in order, and outputs hold stable while stalled.
- start pulsed during SCAN, and vec changed mid-scan → no restart, and data reflects the captured vec.
- rst asserted at index 13 → outputs 0 immediately, no done pulse; next start rescans from index 0.
- ROWS=1, COLS=1, mode 3 → single element, index 0, out_last=1, plain data.

Source files
------------

// File: rtl/vec_scan_pkg.sv
// vec_scan_pkg
// Shared types for the vector scan controller:
//   mode_t     - data transform select (code 3 is reserved and behaves as plain)
//   state_t    - controller FSM states
//   clog2_min1 - index width helper that never returns 0, so a 1-deep
//                dimension still gets a 1-bit counter
package vec_scan_pkg;

    typedef enum logic [1:0] {
        MODE_PLAIN   = 2'd0,
        MODE_INV     = 2'd1,
        MODE_INV_OFS = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter
// Nested row/column counter that walks ROWS x COLS elements in row-major order.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - return to element 0 (has priority over advance)
//   advance   - step to the next element; ignored on the final element
//   row, col  - current position
//   index     - flat element index, row*COLS + col
//   last      - current position is the final element
module scan_counter import vec_scan_pkg::*; #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    localparam int RW = clog2_min1(ROWS),
    localparam int CW = clog2_min1(COLS),
    localparam int IW = clog2_min1(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [IW-1:0] index,
    output logic          last
);

    assign last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

    // The flat index is kept in its own register rather than computed as
    // row*COLS+col, so out_index needs no multiplier and steps by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= '0;
            col   <= '0;
            index <= '0;
        end else if (clear) begin
            row   <= '0;
            col   <= '0;
            index <= '0;
        end else if (advance && !last) begin
            index <= index + 1'b1;
            if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_scan_ctrl.sv
// vec_scan_ctrl
// Restartable scan engine: captures a ROWS*COLS-bit filter vector and emits one
// transformed element per accepted stream handshake, in row-major order.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start       - begin a scan (only honoured in IDLE)
//   mode        - transform: 0 plain, 1 invert, 2 invert+offset, 3 as plain
//   offset      - addend for mode 2
//   vec         - element i is vec[i]; captured at start
//   busy        - controller not idle
//   out_valid / out_ready / out_index / out_data / out_last - element stream
//   done        - one-cycle pulse after the final handshake
//   dbg_state, dbg_row, dbg_col - FSM state and scan position for observation
//
// Stream handshake: an element transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready low, the
// element (out_index, out_data, out_last) holds stable. out_valid never
// depends on out_ready, and no output depends combinationally on any input.
module vec_scan_ctrl import vec_scan_pkg::*; #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int DW   = 8,
    localparam int N  = ROWS * COLS,
    localparam int IW = clog2_min1(N),
    localparam int RW = clog2_min1(ROWS),
    localparam int CW = clog2_min1(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] offset,
    input  logic [N-1:0]  vec,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic [1:0]    dbg_state,
    output logic [RW-1:0] dbg_row,
    output logic [CW-1:0] dbg_col
);

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q;
    logic [1:0]    mode_q;
    logic [DW-1:0] offset_q;

    logic          start_acc;
    logic          hs;
    logic          cnt_clear;
    logic [RW-1:0] cnt_row;
    logic [CW-1:0] cnt_col;
    logic [IW-1:0] cnt_index;
    logic          cnt_last;
    logic [DW-1:0] elem_bit;
    logic [DW-1:0] xf_data;

    assign start_acc = (state_q == S_IDLE) && start;
    assign hs        = out_valid && out_ready;
    // Clearing on the final handshake leaves out_index at 0 while idle.
    assign cnt_clear = start_acc || (hs && cnt_last);

    scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (hs),
        .row     (cnt_row),
        .col     (cnt_col),
        .index   (cnt_index),
        .last    (cnt_last)
    );

    // Capture registers: the scan runs on these, so input changes after
    // start cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            mode_q   <= '0;
            offset_q <= '0;
        end else if (start_acc) begin
            vec_q    <= vec;
            mode_q   <= mode;
            offset_q <= offset;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (hs && cnt_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Element transform; the addition wraps modulo 2^DW.
    always_comb begin
        elem_bit    = '0;
        elem_bit[0] = vec_q[cnt_index];
        case (mode_q)
            MODE_INV:     xf_data = ~elem_bit;
            MODE_INV_OFS: xf_data = ~elem_bit + offset_q;
            default:      xf_data = elem_bit;
        endcase
    end

    // FSM: outputs, decoded from registered state and counter only
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_SCAN);
        done      = (state_q == S_DONE);
        out_last  = (state_q == S_SCAN) && cnt_last;
        out_data  = (state_q == S_SCAN) ? xf_data : '0;
    end

    assign out_index = cnt_index;
    assign dbg_state = state_q;
    assign dbg_row   = cnt_row;
    assign dbg_col   = cnt_col;

endmodule

// File: tb/tb_vec_scan_ctrl.sv
// tb_vec_scan_ctrl
// Directed bench for vec_scan_ctrl: a default 4x8 instance and a 1x1 instance.
module tb_vec_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int N    = ROWS * COLS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance signals
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] offset;
    logic [N-1:0]  vec;
    logic          out_ready;
    logic          busy, out_valid, out_last, done;
    logic [4:0]    out_index;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;
    logic [1:0]    dbg_row;
    logic [2:0]    dbg_col;

    // 1x1 instance signals
    logic          s_start;
    logic [1:0]    s_mode;
    logic [DW-1:0] s_offset;
    logic [0:0]    s_vec;
    logic          s_out_ready;
    logic          s_busy, s_out_valid, s_out_last, s_done;
    logic [0:0]    s_out_index;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_dbg_state;
    logic [0:0]    s_dbg_row;
    logic [0:0]    s_dbg_col;

    vec_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .offset(offset),
        .vec(vec), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .out_last(out_last),
        .done(done), .dbg_state(dbg_state), .dbg_row(dbg_row), .dbg_col(dbg_col)
    );

    vec_scan_ctrl #(.ROWS(1), .COLS(1), .DW(DW)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .offset(s_offset),
        .vec(s_vec), .busy(s_busy), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_index(s_out_index), .out_data(s_out_data), .out_last(s_out_last),
        .done(s_done), .dbg_state(s_dbg_state), .dbg_row(s_dbg_row), .dbg_col(s_dbg_col)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    // entry = {index[4:0], data[7:0], last}
    logic [13:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Scans vec = 0xAAAA_AAAA (bit n = n&1). d_even / d_odd are the hand-computed
    // words for even (bit 0) and odd (bit 1) elements. disturb pulses start and
    // rewrites vec/mode/offset mid-scan, and pulses start again during DONE.
    task automatic run_scan(input logic [1:0] m, input logic [7:0] ofs,
                            input logic [7:0] d_even, input logic [7:0] d_odd,
                            input bit rand_ready, input bit disturb);
        int  done_cnt;
        int  done_cyc;
        int  last_hs_cyc;
        bit  finished;
        logic [13:0] e;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back({5'(i), ((i % 2) == 0) ? d_even : d_odd, 1'(i == N - 1)});
        done_cnt    = 0;
        done_cyc    = -1;
        last_hs_cyc = -100;
        finished    = 1'b0;

        @(negedge clk);
        vec       = 32'hAAAA_AAAA;
        mode      = m;
        offset    = ofs;
        start     = 1'b1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && cyc == 5) begin
                start  = 1'b1;
                vec    = 32'h5555_5555;
                mode   = 2'd1;
                offset = 8'h77;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 1);
                check("valid_at_done", out_valid, 0);
                if (disturb) start = 1'b1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("index", out_index, e[13:9]);
                    check("data", out_data, e[8:1]);
                    check("last", out_last, e[0]);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) last_hs_cyc = cyc;
            end
            if (exp_q.size() == 0 && done_cnt > 0 && !busy) finished = 1'b1;
        end
        start = 1'b0;
        check("scan_complete", finished, 1);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc, last_hs_cyc + 1);
        if (!rand_ready) check("done_latency", done_cyc, N);
    endtask

    task automatic reset_mid_scan();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        vec       = 32'hAAAA_AAAA;
        mode      = 2'd0;
        offset    = 8'h00;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int g = 0; g < 100 && !hit; g++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_index == 5'd13) hit = 1'b1;
        end
        check("reach_idx13", hit, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_index", out_index, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        check("rst_row", dbg_row, 0);
        check("rst_col", dbg_col, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", done, 0);
            check("idle_after_abort", busy, 0);
        end
    endtask

    task automatic single_element();
        @(negedge clk);
        s_vec       = 1'b1;
        s_mode      = 2'd3;
        s_offset    = 8'h10;
        s_start     = 1'b1;
        s_out_ready = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        check("one_valid", s_out_valid, 1);
        check("one_busy", s_busy, 1);
        check("one_index", s_out_index, 0);
        check("one_data", s_out_data, 8'h01);
        check("one_last", s_out_last, 1);
        @(negedge clk);
        check("one_hold_valid", s_out_valid, 1);
        check("one_hold_data", s_out_data, 8'h01);
        check("one_hold_last", s_out_last, 1);
        s_out_ready = 1'b1;
        @(negedge clk);
        check("one_done", s_done, 1);
        check("one_valid_drop", s_out_valid, 0);
        check("one_last_drop", s_out_last, 0);
        s_out_ready = 1'b0;
        @(negedge clk);
        check("one_done_pulse", s_done, 0);
        check("one_idle", s_busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        mode        = 2'd0;
        offset      = '0;
        vec         = '0;
        out_ready   = 1'b0;
        s_start     = 1'b0;
        s_mode      = 2'd0;
        s_offset    = '0;
        s_vec       = '0;
        s_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", out_valid, 0);
        check("reset_index", out_index, 0);
        check("reset_data", out_data, 0);
        check("reset_last", out_last, 0);
        check("reset_done", done, 0);
        check("reset_state", dbg_state, 0);
        check("reset1_valid", s_out_valid, 0);
        check("reset1_last", s_out_last, 0);
        rst = 1'b0;

        run_scan(2'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        run_scan(2'd2, 8'h05, 8'h04, 8'h03, 1'b0, 1'b0);
        run_scan(2'd1, 8'h00, 8'hFF, 8'hFE, 1'b0, 1'b0);
        run_scan(2'd0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        run_scan(2'd2, 8'h05, 8'h04, 8'h03, 1'b1, 1'b0);
        run_scan(2'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1);
        reset_mid_scan();
        run_scan(2'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        single_element();

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
